qq_arbiter: RTL

//  Shares one QuickQ priority queue (qq_top: qq_control + RAM) between N requesters.

---
 rtl/qq_pkg.sv | 16 +
 rtl/qq_arbiter_rr_pick.sv | 32 +++
 rtl/qq_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/qq_pkg.sv
// Shared types and constants for the QuickQ requester arbiter.
package qq_pkg;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Encoding of a requester's op bit.
    localparam logic OP_ENQ = 1'b0;
    localparam logic OP_DEQ = 1'b1;

endpackage

// File: rtl/qq_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr+1 (mod N).
module rr_pick #(
    parameter int N  = 4,
    parameter int NW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [NW-1:0] ptr,
    output logic          valid,
    output logic [NW-1:0] idx
);

    logic [2*N-1:0] dbl;
    int             start;
    int             pos;

    // Rotate a doubled copy of req so the search starts at ptr+1, then take
    // the lowest set bit and map its position back to a requester index.
    always_comb begin
        start = (int'(ptr) + 1) % N;
        dbl   = {req, req} >> start;
        pos   = 0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                pos   = i;
                valid = 1'b1;
            end
        end
        idx = NW'((start + pos) % N);
    end

endmodule

// File: rtl/qq_arbiter.sv
// Round-robin arbiter sharing one QuickQ priority queue between N requesters.
//
// Handshake: a requester raises req[i] (with op[i] and its wdata lane stable)
// and holds it until done[i] or err[i] pulses for one cycle; gnt[i] is high
// from the issue cycle through that response cycle. Toward the queue, a single
// q_enq/q_deq pulse is only issued while q_rdy is high, after which q_rdy is
// ignored for one cycle and then waited on before the response is returned.
module qq_arbiter
    import qq_pkg::*;
#(
    parameter  int W  = 8,
    parameter  int N  = 4,
    localparam int NW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   op,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic [N-1:0]   err,
    output logic [W-1:0]   rdata,
    output logic [NW-1:0]  gnt_idx,
    output logic           q_enq,
    output logic           q_deq,
    output logic [W-1:0]   q_din,
    input  logic [W-1:0]   q_dout,
    input  logic           q_rdy,
    input  logic           q_full,
    input  logic           q_empty,
    output arb_state_t     dbg_state
);

    arb_state_t    state_q, state_d;
    logic [NW-1:0] ptr_q, ptr_d;
    logic [NW-1:0] idx_q, idx_d;
    logic          op_q, op_d;
    logic          rej_q, rej_d;
    logic          first_q, first_d;
    logic [W-1:0]  rdata_q, rdata_d;
    logic [W-1:0]  q_din_q, q_din_d;
    logic          q_enq_q, q_enq_d;
    logic          q_deq_q, q_deq_d;
    logic [N-1:0]  done_q, done_d;
    logic [N-1:0]  err_q, err_d;

    logic          pick_valid;
    logic [NW-1:0] pick_idx;
    logic [N-1:0]  idx_oh;
    logic          pick_op;
    logic          pick_rej;

    rr_pick #(.N(N), .NW(NW)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign idx_oh    = N'(1) << idx_q;
    assign pick_op   = op[pick_idx];
    // Queue status is stable while q_rdy is high, so reject decisions are
    // made at selection time; this lets the queue pulse be a registered
    // output that lands in the ISSUE cycle.
    assign pick_rej  = (pick_op == OP_ENQ) ? q_full : q_empty;

    assign gnt       = (state_q != IDLE) ? idx_oh : '0;
    assign gnt_idx   = idx_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign q_enq     = q_enq_q;
    assign q_deq     = q_deq_q;
    assign q_din     = q_din_q;
    assign dbg_state = state_q;

    // Next-state and registered-output decode for the transaction FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        op_d    = op_q;
        rej_d   = rej_q;
        first_d = 1'b0;
        rdata_d = rdata_q;
        q_din_d = q_din_q;
        q_enq_d = 1'b0;
        q_deq_d = 1'b0;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            IDLE: begin
                if (q_rdy && pick_valid) begin
                    idx_d   = pick_idx;
                    op_d    = pick_op;
                    rej_d   = pick_rej;
                    q_din_d = wdata[int'(pick_idx)*W +: W];
                    q_enq_d = !pick_rej && (pick_op == OP_ENQ);
                    q_deq_d = !pick_rej && (pick_op == OP_DEQ);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (rej_q) begin
                    err_d   = idx_oh;
                    state_d = RESP;
                end else begin
                    // The root holds the minimum until the deq takes effect.
                    if (op_q == OP_DEQ) begin
                        rdata_d = q_dout;
                    end
                    first_d = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // q_rdy may still read high in the cycle right after the pulse.
                if (!first_q && q_rdy) begin
                    done_d  = idx_oh;
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d   = idx_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            op_q    <= OP_ENQ;
            rej_q   <= 1'b0;
            first_q <= 1'b0;
            rdata_q <= '0;
            q_din_q <= '0;
            q_enq_q <= 1'b0;
            q_deq_q <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            rej_q   <= rej_d;
            first_q <= first_d;
            rdata_q <= rdata_d;
            q_din_q <= q_din_d;
            q_enq_q <= q_enq_d;
            q_deq_q <= q_deq_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule
